// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order response tagging,
// output FIFO, flush with stale-response dropping. Optional macro FETCH_BYPASS_EN.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] aq_q    [DEPTH];
  logic [ADDR_W-1:0] faddr_q [DEPTH];
  logic [DATA_W-1:0] fdata_q [DEPTH];

  logic [PW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
  logic [PW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
  logic [CW-1:0] fcnt_q, fcnt_d, pend_q, pend_d, drop_q, drop_d;
  logic [CW:0]   used;
  logic          req_fire, resp_take, resp_drop, fifo_vld, fpush, fpop;
  logic [ADDR_W-1:0] resp_addr;

  // Every slot is either buffered, awaiting a live response, or awaiting a stale one.
  assign used           = {1'b0, fcnt_q} + {1'b0, pend_q} + {1'b0, drop_q};
  assign imem_req_valid = pc_valid && (used < DEPTH_C) && !flush;
  assign imem_req_addr  = pc_addr;
  assign pc_ready       = imem_req_valid && imem_req_ready;
  assign req_fire       = pc_ready;

  assign resp_addr = aq_q[aq_rd_q];
  assign resp_take = imem_resp_valid && (drop_q == '0) && (pend_q != '0) && !flush;
  assign resp_drop = imem_resp_valid && (drop_q != '0) && !flush;
  assign fifo_vld  = (fcnt_q != '0);
  assign fpop      = fifo_vld && inst_ready && !flush;

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp        = resp_take && !fifo_vld;
  assign inst_valid = fifo_vld || byp;
  assign inst_data  = fifo_vld ? fdata_q[f_rd_q] : (byp ? imem_resp_data : '0);
  assign inst_addr  = fifo_vld ? faddr_q[f_rd_q] : (byp ? resp_addr : '0);
  assign fpush      = resp_take && !(byp && inst_ready);
`else
  assign inst_valid = fifo_vld;
  assign inst_data  = fifo_vld ? fdata_q[f_rd_q] : '0;
  assign inst_addr  = fifo_vld ? faddr_q[f_rd_q] : '0;
  assign fpush      = resp_take;
`endif

  always_comb begin
    aq_wr_d = aq_wr_q;
    aq_rd_d = aq_rd_q;
    f_wr_d  = f_wr_q;
    f_rd_d  = f_rd_q;
    fcnt_d  = fcnt_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    if (flush) begin
      aq_wr_d = '0;
      aq_rd_d = '0;
      f_wr_d  = '0;
      f_rd_d  = '0;
      fcnt_d  = '0;
      pend_d  = '0;
      // A response landing in the flush cycle belongs to the discarded set itself.
      drop_d  = drop_q + pend_q
              - CW'(imem_resp_valid && ((drop_q != '0) || (pend_q != '0)));
    end else begin
      if (req_fire)  aq_wr_d = aq_wr_q + PW'(1);
      if (resp_take) aq_rd_d = aq_rd_q + PW'(1);
      if (fpush)     f_wr_d  = f_wr_q + PW'(1);
      if (fpop)      f_rd_d  = f_rd_q + PW'(1);
      pend_d = pend_q + CW'(req_fire) - CW'(resp_take);
      fcnt_d = fcnt_q + CW'(fpush) - CW'(fpop);
      if (resp_drop) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      fcnt_q  <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      aq_wr_q <= aq_wr_d;
      aq_rd_q <= aq_rd_d;
      f_wr_q  <= f_wr_d;
      f_rd_q  <= f_rd_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (req_fire) aq_q[aq_wr_q] <= pc_addr;
    if (fpush) begin
      fdata_q[f_wr_q] <= imem_resp_data;
      faddr_q[f_wr_q] <= resp_addr;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: fixed-latency memory model with flush epochs
// and an expected-instruction queue derived from credit/flush rules.
module tb_instr_fetch_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, pc_valid, pc_ready, flush, imem_req_valid, imem_req_ready;
  logic imem_resp_valid, inst_valid, inst_ready;
  logic [AW-1:0] pc_addr, imem_req_addr, inst_addr;
  logic [DW-1:0] imem_resp_data, inst_data;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_ready(pc_ready),
    .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_addr(inst_addr), .inst_ready(inst_ready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            epoch;
    int            due;
  } mreq_t;

  mreq_t         memq[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_a[$], want_a[$];
  logic [DW-1:0] got_d[$], want_d[$];
  int cyc, s_cyc, epoch, lat, m_credits, total, bad;
  bit rdy_rand;
  logic o_resp, o_req_valid, o_pc_ready, o_inst_valid, m_req_valid, m_inst_valid;
  logic [AW-1:0] o_req_addr, o_inst_addr, m_head;
  logic [DW-1:0] o_inst_data;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // One clock: memory drives its response, outputs are sampled, model advances.
  task automatic step();
    mreq_t r;
    logic  hit;
    imem_req_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    hit             = (memq.size() > 0) && (memq[0].due == cyc);
    imem_resp_valid = hit;
    imem_resp_data  = hit ? mem_word(memq[0].addr) : DW'($urandom);
    #1;
    s_cyc = cyc; o_resp = hit;
    o_req_valid = imem_req_valid; o_req_addr = imem_req_addr; o_pc_ready = pc_ready;
    o_inst_valid = inst_valid; o_inst_addr = inst_addr; o_inst_data = inst_data;
    m_credits    = DEPTH - exp_q.size() - memq.size();
    m_req_valid  = pc_valid && (m_credits > 0) && !flush;
    m_inst_valid = (exp_q.size() > 0);
    if (hit) begin
      r = memq.pop_front();
      if (r.epoch == epoch && !flush && !rst) exp_q.push_back(r.addr);
    end
    if (BYP) m_inst_valid = (exp_q.size() > 0);
    m_head = m_inst_valid ? exp_q[0] : '0;
    if (!rst && !flush && inst_ready) begin
      if (o_inst_valid) begin got_a.push_back(o_inst_addr); got_d.push_back(o_inst_data); end
      if (m_inst_valid) begin
        want_a.push_back(exp_q[0]); want_d.push_back(mem_word(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    if (rst || flush) begin exp_q.delete(); epoch++; end
    if (rst) memq.delete();
    else if (o_pc_ready) begin
      r.addr = pc_addr; r.epoch = epoch; r.due = cyc + lat;
      memq.push_back(r);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b0; rdy_rand = 1'b0;
    step();
    rst = 1'b0;
    got_a.delete(); got_d.delete(); want_a.delete(); want_d.delete();
  endtask

  task automatic test_reset();
    do_reset();
    step();
    total += 5;
    if (o_inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid: got %b want 0", o_inst_valid); end
    if (o_inst_data !== '0) begin bad++; $display("FAIL reset_inst_data: got %h want 0", o_inst_data); end
    if (o_inst_addr !== '0) begin bad++; $display("FAIL reset_inst_addr: got %h want 0", o_inst_addr); end
    if (o_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", o_req_valid); end
    if (o_pc_ready !== 1'b0) begin bad++; $display("FAIL reset_pc_ready: got %b want 0", o_pc_ready); end
  endtask

  task automatic test_stream();
    int first_resp = -1, first_inst = -1, last_inst = -1, nvalid = 0, issued = 0;
    do_reset();
    lat = 1; inst_ready = 1'b1; pc_addr = '0;
    for (int i = 0; i < 12; i++) begin
      pc_valid = (issued < 4);
      step();
      if (o_pc_ready) begin issued++; pc_addr = pc_addr + 32'd4; end
      if (o_resp && first_resp < 0) first_resp = s_cyc;
      if (o_inst_valid) begin
        if (first_inst < 0) first_inst = s_cyc;
        last_inst = s_cyc; nvalid++;
      end
      total++;
      if (o_inst_valid !== m_inst_valid) begin bad++; $display("FAIL stream_valid cyc=%0d: got %b want %b", s_cyc, o_inst_valid, m_inst_valid); end
    end
    total += 3;
    if (first_inst - first_resp != (BYP ? 0 : 1)) begin bad++; $display("FAIL stream_latency: got %0d want %0d", first_inst - first_resp, BYP ? 0 : 1); end
    if (last_inst - first_inst != 3) begin bad++; $display("FAIL stream_span: got %0d want 3", last_inst - first_inst); end
    if (nvalid != 4 || got_a.size() != 4) begin bad++; $display("FAIL stream_count: got %0d/%0d want 4", nvalid, got_a.size()); end
    for (int i = 0; i < got_a.size() && i < 4; i++) begin
      total++;
      if (got_a[i] !== AW'(4 * i) || got_d[i] !== mem_word(AW'(4 * i))) begin
        bad++; $display("FAIL stream_seq[%0d]: got %h/%h want %h/%h", i, got_a[i], got_d[i], AW'(4 * i), mem_word(AW'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    do_reset();
    lat = 1; inst_ready = 1'b0; pc_valid = 1'b1; pc_addr = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_pc_ready) begin acc++; pc_addr = pc_addr + 32'd4; end
    end
    total += 2;
    if (acc != DEPTH) begin bad++; $display("FAIL bp_accepted: got %0d want %0d", acc, DEPTH); end
    if (o_pc_ready !== 1'b0) begin bad++; $display("FAIL bp_stalled: got %b want 0", o_pc_ready); end
    inst_ready = 1'b1;
    step();
    total++;
    if (o_pc_ready !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle: got %b want 0", o_pc_ready); end
    inst_ready = 1'b0;
    step();
    total += 2;
    if (o_pc_ready !== 1'b1) begin bad++; $display("FAIL bp_credit_back: got %b want 1", o_pc_ready); end
    if (o_req_addr !== 32'h10) begin bad++; $display("FAIL bp_next_addr: got %h want 10", o_req_addr); end
    pc_valid = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    total++;
    if (got_a.size() != 5 || want_a.size() != 5) begin bad++; $display("FAIL bp_drain_count: got %0d want 5 (model %0d)", got_a.size(), want_a.size()); end
    for (int i = 0; i < got_a.size() && i < want_a.size(); i++) begin
      total++;
      if (got_a[i] !== want_a[i] || got_d[i] !== want_d[i]) begin bad++; $display("FAIL bp_seq[%0d]: got %h/%h want %h/%h", i, got_a[i], got_d[i], want_a[i], want_d[i]); end
    end
  endtask

  task automatic test_flush();
    int nvalid = 0;
    logic [AW-1:0] fa = '0;
    logic [DW-1:0] fd = '0;
    do_reset();
    lat = 3; inst_ready = 1'b1; pc_valid = 1'b1; pc_addr = 32'h0;
    step();
    total++;
    if (o_pc_ready !== 1'b1) begin bad++; $display("FAIL flush_req0: got %b want 1", o_pc_ready); end
    pc_addr = 32'h4;
    step();
    total++;
    if (o_pc_ready !== 1'b1) begin bad++; $display("FAIL flush_req1: got %b want 1", o_pc_ready); end
    flush = 1'b1; pc_addr = 32'h40;
    step();
    total++;
    if (o_req_valid !== 1'b0) begin bad++; $display("FAIL flush_no_req: got %b want 0", o_req_valid); end
    flush = 1'b0;
    step();
    total++;
    if (o_pc_ready !== 1'b1) begin bad++; $display("FAIL flush_refetch: got %b want 1", o_pc_ready); end
    pc_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_inst_valid) begin
        if (nvalid == 0) begin fa = o_inst_addr; fd = o_inst_data; end
        nvalid++;
      end
    end
    total += 3;
    if (nvalid != 1) begin bad++; $display("FAIL flush_count: got %0d want 1", nvalid); end
    if (fa !== 32'h40) begin bad++; $display("FAIL flush_first_addr: got %h want 40", fa); end
    if (fd !== mem_word(32'h40)) begin bad++; $display("FAIL flush_first_data: got %h want %h", fd, mem_word(32'h40)); end
  endtask

  task automatic test_flush_resp();
    int acc = 0;
    bit done = 1'b0;
    do_reset();
    lat = 2; inst_ready = 1'b1; pc_addr = 32'h100;
    for (int i = 0; i < 20 && !done; i++) begin
      if (memq.size() > 0 && memq[0].due == cyc && acc >= 3) begin
        flush = 1'b1; pc_valid = 1'b0; done = 1'b1;
      end else pc_valid = 1'b1;
      step();
      if (o_pc_ready) begin acc++; pc_addr = pc_addr + 32'd4; end
    end
    total++;
    if (!done || o_resp !== 1'b1) begin bad++; $display("FAIL fr_setup: got done=%0d resp=%b want 1/1", done, o_resp); end
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (o_inst_valid !== 1'b0) begin bad++; $display("FAIL fr_empty cyc=%0d: got %b want 0", s_cyc, o_inst_valid); end
    end
    pc_addr = 32'h200; pc_valid = 1'b1;
    for (int i = 0; i < 8 && pc_valid; i++) begin
      step();
      total++;
      if (o_req_valid !== m_req_valid) begin bad++; $display("FAIL fr_req_valid: got %b want %b", o_req_valid, m_req_valid); end
      if (o_pc_ready) pc_valid = 1'b0;
    end
    pc_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    total++;
    if (got_a.size() == 0 || got_a[got_a.size()-1] !== 32'h200) begin
      bad++; $display("FAIL fr_refetch: got %h want 200", (got_a.size() > 0) ? got_a[got_a.size()-1] : 'x);
    end
    total++;
    if (got_a.size() != want_a.size()) begin bad++; $display("FAIL fr_seq_len: got %0d want %0d", got_a.size(), want_a.size()); end
    for (int i = 0; i < got_a.size() && i < want_a.size(); i++) begin
      total++;
      if (got_a[i] !== want_a[i] || got_d[i] !== want_d[i]) begin bad++; $display("FAIL fr_seq[%0d]: got %h/%h want %h/%h", i, got_a[i], got_d[i], want_a[i], want_d[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    do_reset();
    lat = 3; inst_ready = 1'b0; pc_valid = 1'b1; pc_addr = '0;
    for (int i = 0; i < 12 && !(acc == 4 && memq.size() == 2); i++) begin
      step();
      if (o_pc_ready) begin acc++; pc_addr = pc_addr + 32'd4; end
    end
    total++;
    if (acc != 4) begin bad++; $display("FAIL rm_setup: got %0d want 4", acc); end
    rst = 1'b1; pc_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    total += 2;
    if (o_inst_valid !== 1'b0) begin bad++; $display("FAIL rm_inst_valid: got %b want 0", o_inst_valid); end
    if (o_req_valid !== 1'b0) begin bad++; $display("FAIL rm_req_valid: got %b want 0", o_req_valid); end
    lat = 1; acc = 0; pc_valid = 1'b1; pc_addr = 32'h300;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_pc_ready) begin acc++; pc_addr = pc_addr + 32'd4; end
    end
    total++;
    if (acc != DEPTH) begin bad++; $display("FAIL rm_credits: got %0d want %0d", acc, DEPTH); end
  endtask

  task automatic test_random();
    do_reset();
    for (int seg = 0; seg < 3; seg++) begin
      lat = 1 + seg; rdy_rand = 1'b1;
      got_a.delete(); got_d.delete(); want_a.delete(); want_d.delete();
      pc_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      for (int i = 0; i < 250; i++) begin
        pc_valid   = ($urandom_range(0, 3) != 0);
        flush      = ($urandom_range(0, 19) == 0);
        inst_ready = ($urandom_range(0, 2) != 0);
        step();
        if (flush) pc_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        else if (o_pc_ready) pc_addr = pc_addr + 32'd4;
        total += 3;
        if (o_req_valid !== m_req_valid) begin bad++; $display("FAIL rnd_req_valid cyc=%0d: got %b want %b", s_cyc, o_req_valid, m_req_valid); end
        if (o_pc_ready !== (m_req_valid && imem_req_ready)) begin bad++; $display("FAIL rnd_pc_ready cyc=%0d: got %b want %b", s_cyc, o_pc_ready, m_req_valid && imem_req_ready); end
        if (o_inst_valid !== m_inst_valid) begin bad++; $display("FAIL rnd_inst_valid cyc=%0d: got %b want %b", s_cyc, o_inst_valid, m_inst_valid); end
        if (m_inst_valid) begin
          total++;
          if (o_inst_addr !== m_head || o_inst_data !== mem_word(m_head)) begin
            bad++; $display("FAIL rnd_head cyc=%0d: got %h/%h want %h/%h", s_cyc, o_inst_addr, o_inst_data, m_head, mem_word(m_head));
          end
        end
      end
      pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b1;
      for (int i = 0; i < 12; i++) step();
      total++;
      if (got_a.size() != want_a.size()) begin bad++; $display("FAIL rnd_seq_len seg=%0d: got %0d want %0d", seg, got_a.size(), want_a.size()); end
      for (int i = 0; i < got_a.size() && i < want_a.size(); i++) begin
        total++;
        if (got_a[i] !== want_a[i] || got_d[i] !== want_d[i]) begin bad++; $display("FAIL rnd_seq[%0d]: got %h/%h want %h/%h", i, got_a[i], got_d[i], want_a[i], want_d[i]); end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; epoch = 0; lat = 1; rdy_rand = 1'b0;
    rst = 1'b1; pc_valid = 1'b0; pc_addr = '0; flush = 1'b0; inst_ready = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_resp();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
